// File: rtl/iscb_pkg.sv
// Shared constants and helpers for the ISCB stochastic-computing units.
// Holds the largest supported shuffle-buffer depth and the reset pattern
// that preloads a buffer with the stream value 0.5.
package iscb_pkg;

    localparam int unsigned DEPTH_MAX = 16;

    // Bit i is ~i[0], giving 1,0,1,0,... from index 0 upward.
    function automatic logic [DEPTH_MAX-1:0] buf_reset_pattern();
        logic [DEPTH_MAX-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < DEPTH_MAX; i++) begin
            pat[i] = ~i[0];
        end
        return pat;
    endfunction

endpackage

// File: rtl/iscbsqrt_param_cordiv.sv
// cordiv_param: correlated stochastic divider core.
// The quotient bit passes the input bit straight through when the divisor
// bit is 1. Otherwise it replays a randomly chosen past quotient bit from the
// shuffle buffer. The buffer only records new quotient bits when the divisor
// bit is 1.
module cordiv_param
    import iscb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            d,
    input  logic            in,
    input  logic [IDXW-1:0] rand_idx,
    output logic            q
);

    localparam logic [DEPTH_MAX-1:0] RST_FULL = buf_reset_pattern();
    localparam logic [DEPTH-1:0]     RST_PAT  = RST_FULL[DEPTH-1:0];

    logic [DEPTH-1:0] sbuf;

    // Quotient selection: pass the input through, or replay a buffered bit.
    always_comb begin
        q = d ? in : sbuf[rand_idx];
    end

    // Shuffle buffer: shift in the new quotient bit only when the divisor bit is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf <= RST_PAT;
        end else if (clr) begin
            sbuf <= RST_PAT;
        end else if (en && d) begin
            sbuf <= {sbuf[DEPTH-2:0], q};
        end
    end

endmodule

// File: rtl/iscbsqrt_param.sv
// iscbsqrt_param: stochastic square root, out ~= sqrt(in), latency 1 cycle.
// The divider's quotient is fed back as its own divisor, so in steady state
// q = in / q, which gives q = sqrt(in).
// Optional macro ISCBSQRT_JK_EN: uses a JK flip-flop (J=1, K=q) as the divisor
// instead of the plain feedback register, so the divisor cannot lock at 0.
module iscbsqrt_param
    import iscb_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic            in,
    input  logic [IDXW-1:0] rand_idx,
    output logic            out,
    output logic            out_valid
);

    localparam logic [IDXW:0] CNT_MAX = DEPTH[IDXW:0];

    logic          d;
    logic          q;
    logic [IDXW:0] count;

    cordiv_param #(.DEPTH(DEPTH)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .en       (en),
        .d        (d),
        .in       (in),
        .rand_idx (rand_idx),
        .q        (q)
    );

`ifdef ISCBSQRT_JK_EN
    logic jk;

    // JK divisor: toggles when q=1, sets when q=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jk <= 1'b1;
        end else if (clr) begin
            jk <= 1'b1;
        end else if (en) begin
            jk <= ~jk | ~q;
        end
    end

    assign d = jk;
`else
    logic fb;

    // Plain feedback: the divisor is the previous quotient bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb <= 1'b1;
        end else if (clr) begin
            fb <= 1'b1;
        end else if (en) begin
            fb <= q;
        end
    end

    assign d = fb;
`endif

    // Warm-up counter: counts consumed bits, saturating at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Output register: the quotient bit, one cycle after its input bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 1'b0;
        end else if (clr) begin
            out <= 1'b0;
        end else if (en) begin
            out <= q;
        end
    end

    assign out_valid = (count == CNT_MAX);

endmodule

// File: tb/tb_iscbsqrt_param.sv
// Directed bench for iscbsqrt_param, DEPTH=4, default build (no ISCBSQRT_JK_EN).
module tb_iscbsqrt_param;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       en;
    logic       in;
    logic [1:0] rand_idx;
    logic       out;
    logic       out_valid;

    int unsigned vectors;
    int unsigned miss;

    iscbsqrt_param #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .in        (in),
        .rand_idx  (rand_idx),
        .out       (out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks out, out_valid, count, fb and the shuffle buffer together.
    task automatic chk_all(input string tag, input logic eo, input logic ev,
                           input int unsigned ec, input logic ef, input logic [3:0] eb);
        chk({tag, ".out"},       {31'd0, out},                 {31'd0, eo});
        chk({tag, ".out_valid"}, {31'd0, out_valid},           {31'd0, ev});
        chk({tag, ".count"},     {29'd0, dut.count},           ec);
        chk({tag, ".fb"},        {31'd0, dut.fb},              {31'd0, ef});
        chk({tag, ".buf"},       {28'd0, dut.u_div.sbuf},      {28'd0, eb});
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miss    = 0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        in      = 1'b0;
        rand_idx = 2'd0;

        // Reset state: buffer 1,0,1,0 from index 0 -> 4'b0101.
        #12;
        chk_all("reset", 1'b0, 1'b0, 0, 1'b1, 4'b0101);

        // Constant 1 input: out=1 from the first edge, valid on the 4th.
        @(negedge clk);
        rst_n = 1'b1;
        in    = 1'b1;
        en    = 1'b1;
        step(); chk_all("ones1", 1'b1, 1'b0, 1, 1'b1, 4'b1011);
        step(); chk_all("ones2", 1'b1, 1'b0, 2, 1'b1, 4'b0111);
        step(); chk_all("ones3", 1'b1, 1'b0, 3, 1'b1, 4'b1111);
        step(); chk_all("ones4", 1'b1, 1'b1, 4, 1'b1, 4'b1111);
        step(); chk_all("ones_sat", 1'b1, 1'b1, 4, 1'b1, 4'b1111);

        // clr together with en: restart wins.
        clr = 1'b1;
        step(); chk_all("clr", 1'b0, 1'b0, 0, 1'b1, 4'b0101);
        clr = 1'b0;

        // en pattern 1,0,0,1 with in=1: state frozen while en=0.
        step(); chk_all("en1a", 1'b1, 1'b0, 1, 1'b1, 4'b1011);
        en = 1'b0;
        step(); chk_all("en0a", 1'b1, 1'b0, 1, 1'b1, 4'b1011);
        step(); chk_all("en0b", 1'b1, 1'b0, 1, 1'b1, 4'b1011);
        en = 1'b1;
        step(); chk_all("en1b", 1'b1, 1'b0, 2, 1'b1, 4'b0111);

        // Zero input with rand_idx=0, then probe buffer selection.
        clr = 1'b1;
        step(); chk_all("clr2", 1'b0, 1'b0, 0, 1'b1, 4'b0101);
        clr = 1'b0;
        in  = 1'b0;
        rand_idx = 2'd0;
        step(); chk_all("zero1", 1'b0, 1'b0, 1, 1'b0, 4'b1010);
        step(); chk_all("zero2", 1'b0, 1'b0, 2, 1'b0, 4'b1010);
        rand_idx = 2'd1;
        step(); chk_all("sel1", 1'b1, 1'b0, 3, 1'b1, 4'b1010);
        rand_idx = 2'd0;
        step(); chk_all("shift0", 1'b0, 1'b1, 4, 1'b0, 4'b0100);
        rand_idx = 2'd2;
        step(); chk_all("sel2", 1'b1, 1'b1, 4, 1'b1, 4'b0100);
        rand_idx = 2'd3;
        step(); chk_all("in0_d1", 1'b0, 1'b1, 4, 1'b0, 4'b1000);
        step(); chk_all("sel3", 1'b1, 1'b1, 4, 1'b1, 4'b1000);

        // Asynchronous reset between edges: outputs clear without a clock.
        in = 1'b1;
        rand_idx = 2'd0;
        step(); chk_all("pre_rst", 1'b1, 1'b1, 4, 1'b1, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 0, 1'b1, 4'b0101);
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk_all("post1", 1'b1, 1'b0, 1, 1'b1, 4'b1011);
        step(); chk_all("post2", 1'b1, 1'b0, 2, 1'b1, 4'b0111);
        step(); chk_all("post3", 1'b1, 1'b0, 3, 1'b1, 4'b1111);
        step(); chk_all("post4", 1'b1, 1'b1, 4, 1'b1, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
